// File: rtl/iq_phase_det_if.sv
// iq_phase_det_if: sample-in / phase-and-magnitude-out handshake bus
interface iq_phase_det_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic               out_valid;
  logic               out_ready;
  logic [20:0]        out_phase;
  logic [16:0]        out_mag;
  modport master (output in_valid, in_i, in_q, out_ready, input in_ready, out_valid, out_phase, out_mag);
  modport slave  (input in_valid, in_i, in_q, out_ready, output in_ready, out_valid, out_phase, out_mag);
endinterface

// File: rtl/iq_phase_det.sv
// iq_phase_det: iterative vectoring CORDIC giving phase and magnitude of an IQ sample
module iq_phase_det #(
  parameter int ITER = 16
) (
  input logic          clk,
  input logic          rst,
  iq_phase_det_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  localparam logic [20:0] ATAN [20] = '{
    21'd262144, 21'd154753, 21'd81768, 21'd41506, 21'd20834,
    21'd10427,  21'd5215,   21'd2608,  21'd1304,  21'd652,
    21'd326,    21'd163,    21'd81,    21'd41,    21'd20,
    21'd10,     21'd5,      21'd3,     21'd1,     21'd1
  };
  state_t             state_q, state_d;
  logic [4:0]         k_q, k_d;
  logic signed [23:0] x_q, x_d, y_q, y_d, xr, yr, i_ext, q_ext;
  logic [20:0]        z_q, z_d, zr, phase_q, phase_d;
  logic [16:0]        mag_q, mag_d;
  logic               zero_q, zero_d, neg;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_phase = phase_q;
  assign bus.out_mag   = mag_q;
  assign i_ext = {{4{bus.in_i[15]}}, bus.in_i, 4'b0};
  assign q_ext = {{4{bus.in_q[15]}}, bus.in_q, 4'b0};
  // one micro-rotation driving y towards zero, using pre-update x and y
  always_comb begin
    neg = y_q[23];
    xr  = neg ? x_q - (y_q >>> k_q) : x_q + (y_q >>> k_q);
    yr  = neg ? y_q + (x_q >>> k_q) : y_q - (x_q >>> k_q);
    zr  = neg ? z_q - ATAN[k_q] : z_q + ATAN[k_q];
  end
  // FSM next state, datapath load/iterate and result capture
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    phase_d = phase_q;
    mag_d   = mag_q;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = ROTATE;
      k_d     = '0;
      x_d     = bus.in_i[15] ? -i_ext : i_ext;
      y_d     = bus.in_i[15] ? -q_ext : q_ext;
      z_d     = bus.in_i[15] ? 21'h100000 : '0;
      zero_d  = bus.in_i == '0 && bus.in_q == '0;
    end else if (state_q == ROTATE) begin
      x_d = xr;
      y_d = yr;
      z_d = zr;
      k_d = k_q + 5'd1;
      if (k_q == 5'(ITER - 1)) begin
        state_d = DONE;
        phase_d = zero_q ? '0 : zr;
        mag_d   = (zero_q || xr[23]) ? '0 : (|xr[22:21]) ? '1 : xr[20:4];
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  // state register with synchronous reset that discards any sample in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      phase_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      phase_q <= phase_d;
      mag_q   <= mag_d;
    end
  end
endmodule

// File: doc/iq_phase_det.md
IQ_PHASE_DET -- requirements
Module: iq_phase_det

Interface
REQ-001 Parameter ITER, default 16, number of CORDIC micro-rotations; legal range 8..20.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  input sample present.
REQ-005 in_ready  output  1  block can accept a sample.
REQ-006 in_i  input  16  signed in-phase sample, two's complement.
REQ-007 in_q  input  16  signed quadrature sample, two's complement.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_phase  output  21  unsigned phase word; full turn = 2^21, bit 20 = half turn.
REQ-011 out_mag  output  17  unsigned magnitude including CORDIC gain (about 1.6468).

Function
REQ-012 The block SHALL compute out_phase = round(atan2(in_q, in_i) * 2^21 / 2pi) mod 2^21, so that the phase-to-sine generator driven with out_phase yields a sine of about in_q/|v|.
REQ-013 The block SHALL implement an FSM with states IDLE, ROTATE and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE. A sample is accepted on an edge where in_valid and in_ready are both 1. On acceptance the FSM moves to ROTATE with iteration counter k = 0.
REQ-015 On acceptance, the datapath SHALL be initialised as follows:
- x, y are 24-bit signed: x = in_i*16, y = in_q*16 (4 guard bits).
- z is a 21-bit accumulator, z = 0.
- If in_i < 0: x = -in_i*16, y = -in_q*16, z = 2^20 (pre-rotation by 180 degrees).
REQ-016 Each ROTATE cycle SHALL perform one micro-rotation, then increment k:
- If y >= 0: x += y>>>k, y -= x>>>k, z += ATAN[k].
- Else: x -= y>>>k, y += x>>>k, z -= ATAN[k].
- Both updates use pre-update x and y.
- z wraps modulo 2^21.
REQ-017 ATAN[k] SHALL be round(atan(2^-k) * 2^21 / 2pi), held as a 20-entry constant table (ATAN[0] = 262144, ATAN[1] = 154753, ATAN[2] = 81768).
REQ-018 After the micro-rotation with k = ITER-1, the FSM SHALL enter DONE. Latency is exactly ITER cycles from the accepting edge to the rise of out_valid.
REQ-019 out_valid SHALL be 1 only in DONE. out_phase and out_mag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 On an edge with out_valid=1 and out_ready=1, the FSM SHALL return to IDLE. A new sample is not accepted on that same edge, so throughput is one sample per ITER+2 cycles.
REQ-021 out_mag SHALL be final x>>4, saturated to 131071.
REQ-022 Zero vector: if in_i = 0 and in_q = 0, the block SHALL output out_phase = 0 and out_mag = 0 exactly, using a flag captured at acceptance, with unchanged latency.
REQ-023 Extreme inputs SHALL be handled without overflow:
- in_i = -32768 and/or in_q = -32768, since negation is done in 24 bits.
- in_i < 0 with in_q = 0 SHALL give out_phase = 2^20 ± tolerance.
REQ-024 Accuracy: for ITER = 16 and |v| >= 4096, |out_phase error| SHALL be <= 64 LSB (circular distance) and |out_mag - 1.6468*|v|| SHALL be <= 8.
REQ-025 in_valid SHALL be ignored outside IDLE. in_i and in_q need not be held after acceptance.

Reset
REQ-026 While rst=1 at an edge, the block SHALL:
- enter IDLE, with in_ready=1 and out_valid=0 after that edge;
- set out_phase=0 and out_mag=0;
- clear k, x, y, z and the zero flag.
REQ-027 rst SHALL override all handshakes. A sample in flight in ROTATE or DONE SHALL be discarded and never emitted. in_valid during rst SHALL NOT be accepted.

Verification
REQ-028 in_i=16384, in_q=0 -> out_phase 0 ±64 (wrap-aware), out_mag 26981 ±8, out_valid exactly 16 cycles after accept.
REQ-029 in_i=0, in_q=16384 -> out_phase 524288 ±64; in_i=0, in_q=-16384 -> out_phase 1572864 ±64.
REQ-030 in_i=-16384, in_q=0 -> 1048576 ±64; in_i=-32768, in_q=-32768 -> 1310720 ±64, out_mag 76314 ±16; in_i=0, in_q=0 -> out_phase 0, out_mag 0 exactly.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. Raise out_ready -> IDLE next cycle, next sample accepted the cycle after.
REQ-032 Reset mid-ROTATE (k=7) -> out_valid=0 and in_ready=1 after the reset edge, and no result for that sample ever appears.
REQ-033 Random sweep of 10,000 vectors with |v| >= 4096, random in_valid/out_ready -> every result within REQ-024 tolerance and in input order.
